// File: rtl/sync_pkg.sv
// Shared defaults, counter-width helper and per-channel edge-event type for the
// multi-channel level synchroniser.
package sync_pkg;

   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned SYNC_FILTER_DEF = 4;

   typedef struct packed {
      logic rise;
      logic fall;
   } sync_edge_t;

   // Wide enough to hold 0..n inclusive.
   function automatic int unsigned sync_cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sync_edge_bit.sv
// One synchroniser channel: flop chain, optional stability filter, edge pulses.
// Glitch filter is built when SYNC_MULTI_EDGE_FILTER_EN is defined.
module sync_edge_bit
   import sync_pkg::*;
#(
   parameter int unsigned STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned FILTER_CNT = SYNC_FILTER_DEF,
   parameter logic        RESET_VAL  = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       d_i,
   output logic       q_o,
   output sync_edge_t edge_o
);

   if (STAGES < 2) begin : g_bad_stages
      $error("sync_edge_bit: STAGES must be >= 2");
   end
   if (FILTER_CNT < 1) begin : g_bad_filter
      $error("sync_edge_bit: FILTER_CNT must be >= 1");
   end

   logic [STAGES-1:0] chain_q;
   logic              synced;
   logic              lvl;
   logic              q_prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= {STAGES{RESET_VAL}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign synced = chain_q[STAGES-1];

`ifdef SYNC_MULTI_EDGE_FILTER_EN
   localparam int unsigned      CNT_W    = sync_cnt_w(FILTER_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lvl_q, lvl_d;

   // Counter clears on match or on update, so it never exceeds CNT_LAST.
   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (synced != lvl_q) begin
         if (cnt_q == CNT_LAST) begin
            lvl_d = synced;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lvl_q <= RESET_VAL;
         cnt_q <= '0;
      end else begin
         lvl_q <= lvl_d;
         cnt_q <= cnt_d;
      end
   end

   assign lvl = lvl_q;
`else
   assign lvl = synced;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_prev_q <= RESET_VAL;
      end else begin
         q_prev_q <= lvl;
      end
   end

   assign q_o         = lvl;
   assign edge_o.rise = lvl & ~q_prev_q;
   assign edge_o.fall = ~lvl & q_prev_q;

endmodule

// File: rtl/sync_multi_edge.sv
// WIDTH independent level synchronisers with rise/fall pulses and a change flag.
// Per-channel glitch filter is enabled by defining SYNC_MULTI_EDGE_FILTER_EN.
module sync_multi_edge
   import sync_pkg::*;
#(
   parameter int unsigned      WIDTH      = 8,
   parameter int unsigned      STAGES     = SYNC_STAGES_DEF,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter int unsigned      FILTER_CNT = SYNC_FILTER_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sync_edge_t ch_edge;

      sync_edge_bit #(
         .STAGES    (STAGES),
         .FILTER_CNT(FILTER_CNT),
         .RESET_VAL (RESET_VAL[i])
      ) u_bit (
         .clk_i (clk),
         .rst_ni(rst_n),
         .d_i   (d[i]),
         .q_o   (q[i]),
         .edge_o(ch_edge)
      );

      assign rise[i] = ch_edge.rise;
      assign fall[i] = ch_edge.fall;
   end

   assign changed = |(rise | fall);

endmodule
